// File: rtl/alu_sort_sequencer.sv
// Loads DEPTH words, sorts them ascending (unsigned) by odd-even transposition using the
// execute-stage ALU's min/max commands, then streams the sorted block out.
module alu_sort_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    input  logic [31:0] alu_result
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
    localparam logic [CW+1:0] DEPTH_X = (CW+2)'(DEPTH);
    localparam logic [3:0]    CMD_MIN = 4'b1110;
    localparam logic [3:0]    CMD_MAX = 4'b1111;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_PASS  = 3'd1,
        S_MIN   = 3'd2,
        S_MAX   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e        state_q;
    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic [CW-1:0] pass_q;
    logic [CW-1:0] idx_q;
    logic [31:0]   tmp_q;

    logic [CW-1:0] idx_p1_s;
    logic          pass_has_pair_s;
    logic          more_pairs_s;

    assign idx_p1_s        = idx_q + CW'(1);
    // An odd pass has no pair at all only when DEPTH is 2.
    assign pass_has_pair_s = ((CW+2)'(pass_q[0]) + (CW+2)'(1)) < DEPTH_X;
    assign more_pairs_s    = ({2'b00, idx_q} + (CW+2)'(3)) < DEPTH_X;

    // Sequencer FSM: buffer, counters and comparison scratch register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            pass_q   <= '0;
            idx_q    <= '0;
            tmp_q    <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        mem_q[wr_cnt_q] <= in_data;
                        if (wr_cnt_q == LAST) begin
                            wr_cnt_q <= '0;
                            pass_q   <= '0;
                            state_q  <= S_PASS;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                        end
                    end
                end
                S_PASS: begin
                    idx_q <= CW'(pass_q[0]);
                    if (pass_has_pair_s) begin
                        state_q <= S_MIN;
                    end else if (pass_q == LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        pass_q <= pass_q + CW'(1);
                    end
                end
                S_MIN: begin
                    tmp_q   <= alu_result;
                    state_q <= S_MAX;
                end
                S_MAX: begin
                    mem_q[idx_q]    <= tmp_q;
                    mem_q[idx_p1_s] <= alu_result;
                    if (more_pairs_s) begin
                        idx_q   <= idx_q + CW'(2);
                        state_q <= S_MIN;
                    end else if (pass_q == LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        pass_q  <= pass_q + CW'(1);
                        state_q <= S_PASS;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_cnt_q == LAST) begin
                            rd_cnt_q <= '0;
                            state_q  <= S_LOAD;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    // Output decode from registered state only; no input-to-output path.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 32'd0;
        busy      = 1'b0;
        alu_cmd   = 4'b0000;
        alu_val1  = 32'd0;
        alu_val2  = 32'd0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
            end
            S_PASS: begin
                busy = 1'b1;
            end
            S_MIN: begin
                busy     = 1'b1;
                alu_cmd  = CMD_MIN;
                alu_val1 = mem_q[idx_q];
                alu_val2 = mem_q[idx_p1_s];
            end
            S_MAX: begin
                busy     = 1'b1;
                alu_cmd  = CMD_MAX;
                alu_val1 = mem_q[idx_q];
                alu_val2 = mem_q[idx_p1_s];
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = mem_q[rd_cnt_q];
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sort_sequencer.sv
// Scoreboard bench for alu_sort_sequencer: DEPTH=8 and DEPTH=2 instances, each with a
// behavioural min/max ALU on its ports; expected outputs come from a reference sort.
module tb_alu_sort_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [31:0] in_data8, out_data8, v1_8, v2_8, res8;
    logic [3:0]  cmd8;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [31:0] in_data2, out_data2, v1_2, v2_2, res2;
    logic [3:0]  cmd2;

    assign res8 = (cmd8 == 4'b1110) ? ((v1_8 < v2_8) ? v1_8 : v2_8) :
                  (cmd8 == 4'b1111) ? ((v1_8 > v2_8) ? v1_8 : v2_8) : 32'd0;
    assign res2 = (cmd2 == 4'b1110) ? ((v1_2 < v2_2) ? v1_2 : v2_2) :
                  (cmd2 == 4'b1111) ? ((v1_2 > v2_2) ? v1_2 : v2_2) : 32'd0;

    alu_sort_sequencer #(.DEPTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .busy(busy8), .alu_cmd(cmd8), .alu_val1(v1_8), .alu_val2(v2_8),
        .alu_result(res8)
    );

    alu_sort_sequencer #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .alu_cmd(cmd2), .alu_val1(v1_2), .alu_val2(v2_2),
        .alu_result(res2)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp8[$];
    logic [31:0] exp2[$];
    logic [3:0]  tr_cmd[$];
    logic [31:0] tr_v1[$];
    logic [31:0] tr_v2[$];
    logic [31:0] blk8[8];
    int  busy_run8 = 0, last_busy8 = 0, viol8 = 0, busy_run2 = 0, last_busy2 = 0;
    bit  rdy_rand8 = 1'b0;
    logic        prev_stall8 = 1'b0;
    logic [31:0] prev_data8 = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: ascending unsigned order via insertion into a queue.
    task automatic load8(input int gap_max);
        logic [31:0] s[$];
        for (int i = 0; i < 8; i++) begin
            int p = 0;
            while (p < s.size() && s[p] <= blk8[i]) p++;
            s.insert(p, blk8[i]);
        end
        foreach (s[k]) exp8.push_back(s[k]);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            int g;
            int t;
            bit hs;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            in_valid8 = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid8 = 1'b1;
            in_data8  = blk8[i];
            t = 0;
            hs = 1'b0;
            while (!hs && t < 500) begin
                @(negedge clk); hs = in_ready8;
                @(posedge clk); #1; t++;
            end
            if (!hs) begin
                check("load8_timeout", 32'(hs), 32'd1);
                in_valid8 = 1'b0;
                return;
            end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic load2w(input logic [31:0] w);
        int t = 0;
        bit hs = 1'b0;
        in_valid2 = 1'b1;
        in_data2  = w;
        while (!hs && t < 500) begin
            @(negedge clk); hs = in_ready2;
            @(posedge clk); #1; t++;
        end
        if (!hs) check("load2_timeout", 32'(hs), 32'd1);
        in_valid2 = 1'b0;
    endtask

    task automatic wait_drain8();
        int t = 0;
        while (exp8.size() != 0 && t < 3000) begin @(posedge clk); t++; end
        check("drain8_remaining", 32'(exp8.size()), 32'd0);
        @(negedge clk);
    endtask

    // Random or constant consumer backpressure for the DEPTH=8 instance.
    initial begin
        out_ready8 = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready8 = rdy_rand8 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor DEPTH=8: scoreboard pop, stall stability, busy length, ALU trace.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_run8   = 0;
                prev_stall8 = 1'b0;
            end else begin
                if (prev_stall8) begin
                    check("stall_valid8", 32'(out_valid8), 32'd1);
                    check("stall_data8", out_data8, prev_data8);
                end
                if (out_valid8 && out_ready8) begin
                    if (exp8.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_word8: got 0x%08h expected no word", out_data8);
                    end else begin
                        e = exp8.pop_front();
                        check("out_data8", out_data8, e);
                    end
                end
                prev_stall8 = out_valid8 && !out_ready8;
                prev_data8  = out_data8;
                if (busy8) begin
                    busy_run8++;
                    if (in_ready8 || out_valid8) viol8++;
                end else if (busy_run8 != 0) begin
                    last_busy8 = busy_run8;
                    busy_run8  = 0;
                end
                if (cmd8 != 4'b0000) begin
                    tr_cmd.push_back(cmd8);
                    tr_v1.push_back(v1_8);
                    tr_v2.push_back(v2_8);
                end
            end
        end
    end

    // Monitor DEPTH=2: scoreboard pop and busy length.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_run2 = 0;
            end else begin
                if (out_valid2 && out_ready2) begin
                    if (exp2.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_word2: got 0x%08h expected no word", out_data2);
                    end else begin
                        e = exp2.pop_front();
                        check("out_data2", out_data2, e);
                    end
                end
                if (busy2) begin
                    busy_run2++;
                end else if (busy_run2 != 0) begin
                    last_busy2 = busy_run2;
                    busy_run2  = 0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int cnt;
        int t;
        logic [3:0]  c0;
        logic [31:0] f1, f2;
        logic [31:0] uns_in[8];
        logic [31:0] fresh[8];
        uns_in = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h5, 32'h5, 32'h1, 32'h80000000};
        fresh  = '{32'd3, 32'd1, 32'd2, 32'd8, 32'd6, 32'd5, 32'd7, 32'd4};
        rst = 1'b0;
        in_valid8 = 1'b0; in_data8 = 32'd0;
        in_valid2 = 1'b0; in_data2 = 32'd0; out_ready2 = 1'b1;

        @(negedge clk);
        check("rst_in_ready", 32'(in_ready8), 32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_out_data", out_data8, 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_alu_cmd", 32'(cmd8), 32'd0);
        check("rst_alu_val1", v1_8, 32'd0);
        check("rst_alu_val2", v2_8, 32'd0);
        check("rst_in_ready2", 32'(in_ready2), 32'd1);
        @(posedge clk); #1 rst = 1'b1;

        // Reverse input with ALU trace capture.
        for (int i = 0; i < 8; i++) blk8[i] = 32'(8 - i);
        tr_cmd.delete(); tr_v1.delete(); tr_v2.delete();
        viol8 = 0;
        load8(0);
        wait_drain8();
        check("rev_busy_len", 32'(last_busy8), 32'd64);
        check("rev_inready_in_sort", 32'(viol8), 32'd0);
        check("trace_pairs", 32'(tr_cmd.size() / 2), 32'd28);
        check("trace_odd_len", 32'(tr_cmd.size() % 2), 32'd0);
        bad = 0;
        for (int i = 0; i + 1 < tr_cmd.size(); i += 2) begin
            if (tr_cmd[i] !== 4'b1110 || tr_cmd[i+1] !== 4'b1111 ||
                tr_v1[i] !== tr_v1[i+1] || tr_v2[i] !== tr_v2[i+1]) bad++;
        end
        check("trace_alternation_errors", 32'(bad), 32'd0);
        c0 = 4'd0; f1 = 32'd0; f2 = 32'd0;
        if (tr_cmd.size() > 0) begin c0 = tr_cmd[0]; f1 = tr_v1[0]; f2 = tr_v2[0]; end
        check("trace_first_cmd", 32'(c0), 32'd14);
        check("trace_first_val1", f1, 32'd8);
        check("trace_first_val2", f2, 32'd7);

        // Unsigned ordering corner values.
        for (int i = 0; i < 8; i++) blk8[i] = uns_in[i];
        load8(0);
        wait_drain8();
        check("uns_busy_len", 32'(last_busy8), 32'd64);

        // Handshake stress over 50 random blocks.
        rdy_rand8 = 1'b1;
        viol8 = 0;
        for (int b = 0; b < 50; b++) begin
            for (int i = 0; i < 8; i++)
                blk8[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7));
            load8(3);
        end
        wait_drain8();
        rdy_rand8 = 1'b0;
        check("stress_inready_in_sort", 32'(viol8), 32'd0);

        // Reset in the 20th busy cycle, then a fresh block.
        for (int i = 0; i < 8; i++) blk8[i] = $urandom;
        load8(0);
        cnt = 0; t = 0;
        while (cnt < 20 && t < 300) begin
            @(negedge clk);
            if (busy8) cnt++;
            t++;
        end
        check("midsort_reached_20", 32'(cnt), 32'd20);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready8), 32'd1);
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_alu_cmd", 32'(cmd8), 32'd0);
        check("midrst_alu_val1", v1_8, 32'd0);
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        exp8.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) blk8[i] = fresh[i];
        load8(0);
        wait_drain8();
        check("fresh_busy_len", 32'(last_busy8), 32'd64);

        // DEPTH=2 instance: 9, 4.
        exp2.push_back(32'd4);
        exp2.push_back(32'd9);
        @(posedge clk); #1;
        load2w(32'd9);
        load2w(32'd4);
        t = 0;
        while (exp2.size() != 0 && t < 200) begin @(posedge clk); t++; end
        check("d2_remaining", 32'(exp2.size()), 32'd0);
        @(negedge clk);
        check("d2_busy_len", 32'(last_busy2), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
